// File: rtl/morra_pkg.sv
// morra_pkg: move/result/state encodings and the move-dominance rule for the match engine.
package morra_pkg;

    typedef enum logic [1:0] {MV_NONE, MV_ROCK, MV_PAPER, MV_SCISSORS} move_t;
    typedef enum logic [1:0] {M_INV, M_P1, M_P2, M_DRAW} manche_t;
    typedef enum logic [1:0] {P_NONE, P_P1, P_P2, P_DRAW} partita_t;
    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_DONE} state_t;

    function automatic logic beats(move_t a, move_t b);
        return (a == MV_ROCK && b == MV_SCISSORS) || (a == MV_SCISSORS && b == MV_PAPER) ||
               (a == MV_PAPER && b == MV_ROCK);
    endfunction

    // Wide enough for the largest possible max-round count.
    function automatic int cnt_width(int cfg_w, int min_r);
        return $clog2(2 ** cfg_w - 1 + min_r + 1);
    endfunction

endpackage

// File: rtl/morra_cinese_gen_if.sv
// morra_cinese_gen_if: sampled command/move inputs and registered match outputs.
interface morra_cinese_gen_if #(
    parameter int CFG_W = 4,
    parameter int CNT_W = 5
);
    logic             VALID;
    logic             INIZIA;
    logic [CFG_W-1:0] CFG;
    logic [1:0]       PRIMO;
    logic [1:0]       SECONDO;
    logic             MANCHE_VALID;
    logic [1:0]       MANCHE;
    logic [1:0]       PARTITA;
    logic [CNT_W-1:0] SCORE1;
    logic [CNT_W-1:0] SCORE2;
    logic [CNT_W-1:0] ROUNDS;

    modport master (
        output VALID, INIZIA, CFG, PRIMO, SECONDO,
        input  MANCHE_VALID, MANCHE, PARTITA, SCORE1, SCORE2, ROUNDS
    );
    modport slave (
        input  VALID, INIZIA, CFG, PRIMO, SECONDO,
        output MANCHE_VALID, MANCHE, PARTITA, SCORE1, SCORE2, ROUNDS
    );
endinterface

// File: rtl/morra_judge.sv
// morra_judge: combinational round judge; validity (incl. repeat restriction) and winner.
module morra_judge
    import morra_pkg::*;
(
    input  move_t   p1_i,
    input  move_t   p2_i,
    input  move_t   rmove_i,
    input  manche_t rwho_i,
    output logic    valid_o,
    output manche_t manche_o
);
    assign valid_o = p1_i != MV_NONE && p2_i != MV_NONE &&
                     !(rwho_i == M_P1 && p1_i == rmove_i) &&
                     !(rwho_i == M_P2 && p2_i == rmove_i);
    assign manche_o = !valid_o ? M_INV : p1_i == p2_i ? M_DRAW : beats(p1_i, p2_i) ? M_P1 : M_P2;
endmodule

// File: rtl/morra_cinese_gen.sv
// morra_cinese_gen: rock-paper-scissors match engine with early-win margin and registered outputs.
// Define MORRA_NO_REPEAT_EN to forbid a manche winner from replaying their winning move.
module morra_cinese_gen
    import morra_pkg::*;
#(
    parameter int CFG_W      = 4,
    parameter int MIN_ROUNDS = 4,
    parameter int WIN_MARGIN = 2
) (
    input logic               clk,
    input logic               rst_n,
    morra_cinese_gen_if.slave bus
);
    localparam int CNT_W = cnt_width(CFG_W, MIN_ROUNDS);
    localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_ROUNDS);
    localparam logic signed [CNT_W:0] MARGIN_C = (CNT_W + 1)'(WIN_MARGIN);

    state_t                  state_q;
    logic                    mv_q;
    manche_t                 manche_q, res, rwho;
    partita_t                partita_q, cmp;
    move_t                   rmove;
    logic [CNT_W-1:0]        max_q, s1_q, s2_q, r_q, s1_d, s2_d, r_d;
    logic signed [CNT_W:0]   diff;
    logic                    ok, count, fin;

    morra_judge u_judge (
        .p1_i    (move_t'(bus.PRIMO)),
        .p2_i    (move_t'(bus.SECONDO)),
        .rmove_i (rmove),
        .rwho_i  (rwho),
        .valid_o (ok),
        .manche_o(res)
    );

    // Post-update counters feed the end check in the same cycle.
    assign count = bus.VALID && !bus.INIZIA && state_q == S_PLAY && ok;
    assign s1_d  = s1_q + CNT_W'(count && res == M_P1);
    assign s2_d  = s2_q + CNT_W'(count && res == M_P2);
    assign r_d   = r_q + CNT_W'(count);
    assign diff  = $signed({1'b0, s1_d}) - $signed({1'b0, s2_d});
    assign cmp   = s1_d > s2_d ? P_P1 : s1_d < s2_d ? P_P2 : P_DRAW;
    assign fin   = count && ((r_d >= MIN_C && (diff >= MARGIN_C || -diff >= MARGIN_C)) || r_d == max_q);

`ifdef MORRA_NO_REPEAT_EN
    move_t   rmove_q;
    manche_t rwho_q;
    assign rmove = rmove_q;
    assign rwho  = rwho_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rwho_q  <= M_INV;
            rmove_q <= MV_NONE;
        end else if (bus.VALID && (bus.INIZIA || count)) begin
            rwho_q  <= bus.INIZIA || res == M_DRAW ? M_INV : res;
            rmove_q <= res == M_P1 ? move_t'(bus.PRIMO) : move_t'(bus.SECONDO);
        end
`else
    assign rmove = MV_NONE;
    assign rwho  = M_INV;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mv_q      <= 1'b0;
            manche_q  <= M_INV;
            partita_q <= P_NONE;
            max_q     <= '0;
            s1_q      <= '0;
            s2_q      <= '0;
            r_q       <= '0;
        end else begin
            mv_q <= bus.VALID;
            if (bus.VALID && bus.INIZIA) begin
                state_q   <= S_PLAY;
                manche_q  <= M_INV;
                partita_q <= P_NONE;
                max_q     <= CNT_W'(bus.CFG) + MIN_C;
                s1_q      <= '0;
                s2_q      <= '0;
                r_q       <= '0;
            end else if (bus.VALID) begin
                manche_q <= state_q == S_PLAY ? res : M_INV;
                s1_q     <= s1_d;
                s2_q     <= s2_d;
                r_q      <= r_d;
                if (fin) begin
                    state_q   <= S_DONE;
                    partita_q <= cmp;
                end
            end
        end
    end

    assign bus.MANCHE_VALID = mv_q;
    assign bus.MANCHE       = manche_q;
    assign bus.PARTITA      = partita_q;
    assign bus.SCORE1       = s1_q;
    assign bus.SCORE2       = s2_q;
    assign bus.ROUNDS       = r_q;
endmodule

// File: tb/tb_morra_cinese_gen.sv
// tb_morra_cinese_gen: directed plus random matches checked against an arithmetic game model.
module tb_morra_cinese_gen;
    localparam int MIN_R = 4;
    localparam int MARG  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass = 0;
    int   n_chk = 0;

    always #5 clk = ~clk;

    morra_cinese_gen_if #(.CFG_W(4), .CNT_W(5)) bus ();
    morra_cinese_gen dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // Model: st 0 idle, 1 playing, 2 over
    int st, sc1, sc2, rn, maxr, e_mv, e_man, e_par;
`ifdef MORRA_NO_REPEAT_EN
    int lw, lm;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".mv"}, 32'(bus.MANCHE_VALID), e_mv);
        chk({tag, ".manche"}, 32'(bus.MANCHE), e_man);
        chk({tag, ".partita"}, 32'(bus.PARTITA), e_par);
        chk({tag, ".score1"}, 32'(bus.SCORE1), sc1);
        chk({tag, ".score2"}, 32'(bus.SCORE2), sc2);
        chk({tag, ".rounds"}, 32'(bus.ROUNDS), rn);
    endtask

    task automatic model_reset();
        st = 0; sc1 = 0; sc2 = 0; rn = 0; maxr = 0; e_mv = 0; e_man = 0; e_par = 0;
`ifdef MORRA_NO_REPEAT_EN
        lw = 0; lm = 0;
`endif
    endtask

    task automatic model(input int v, input int iz, input int cfg, input int p1, input int p2);
        int ok, o, d;
        e_mv = v;
        if (!v) return;
        e_man = 0;
        if (iz) begin
            st = 1; sc1 = 0; sc2 = 0; rn = 0; maxr = cfg + MIN_R; e_par = 0;
`ifdef MORRA_NO_REPEAT_EN
            lw = 0;
`endif
            return;
        end
        if (st != 1) return;
        ok = (p1 != 0 && p2 != 0);
`ifdef MORRA_NO_REPEAT_EN
        if ((lw == 1 && p1 == lm) || (lw == 2 && p2 == lm)) ok = 0;
`endif
        if (!ok) return;
        o = (p1 - p2 + 3) % 3;
        rn++;
        if (o == 0) e_man = 3;
        else if (o == 1) begin sc1++; e_man = 1; end
        else begin sc2++; e_man = 2; end
`ifdef MORRA_NO_REPEAT_EN
        lw = (o == 0) ? 0 : o;
        lm = (o == 1) ? p1 : p2;
`endif
        d = sc1 - sc2;
        if ((rn >= MIN_R && (d >= MARG || -d >= MARG)) || rn == maxr) begin
            st = 2;
            e_par = d > 0 ? 1 : d < 0 ? 2 : 3;
        end
    endtask

    task automatic step(input string tag, input int v, input int iz, input int cfg, input int p1, input int p2);
        @(negedge clk);
        bus.VALID = v[0]; bus.INIZIA = iz[0]; bus.CFG = cfg[3:0];
        bus.PRIMO = p1[1:0]; bus.SECONDO = p2[1:0];
        @(posedge clk);
        #1;
        model(v, iz, cfg, p1, p2);
        check_all(tag);
    endtask

    task automatic play(input string tag, input int p1, input int p2);
        step(tag, 1, 0, 0, p1, p2);
    endtask

    task automatic start(input string tag, input int cfg);
        step(tag, 1, 1, cfg, 0, 0);
    endtask

    task automatic mid_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.VALID = 0; bus.INIZIA = 0; bus.CFG = 0; bus.PRIMO = 0; bus.SECONDO = 0;
        model_reset();
        #12;
        check_all("reset");
        rst_n = 1'b1;
        play("idle_play", 2, 1);

        // Early win for P2 at round 4
        start("m1_start", 1);
        play("m1_r1", 1, 2);
        play("m1_r2", 3, 1);
        play("m1_r3", 2, 3);
        play("m1_r4", 3, 2);
        play("m1_done", 2, 1);

        // Draw at max rounds
        start("m2_start", 1);
        repeat (3) play("m2_draw", 3, 3);
        play("m2_r4", 3, 1);
        play("m2_r5", 1, 3);

        // Repeat restriction (or plain play without it)
        start("m3_start", 1);
        play("m3_p2rock", 3, 1);
        play("m3_rockrock", 1, 1);
        play("m3_paperrock", 2, 1);

        // Invalid moves and idle cycles
        play("m3_zero", 0, 2);
        step("m3_novalid", 0, 0, 0, 2, 1);
        step("m3_novalid2", 0, 1, 5, 1, 3);
        play("m3_zero2", 2, 0);

        // Longest match with CFG=9: 13 draws
        start("m4_start", 9);
        repeat (13) play("m4_draw", 2, 2);
        play("m4_after", 1, 3);

        start("m5_start", 3);
        play("m5_r1", 1, 3);
        play("m5_r2", 3, 2);
        mid_reset("m5_reset");
        play("m5_idle", 1, 3);

        for (int i = 0; i < 600; i++) begin
            if (i % 150 == 149) mid_reset("rnd_reset");
            else if ($urandom_range(0, 19) == 0)
                step("rnd_start", 1, 1, $urandom_range(0, 15), 0, 0);
            else
                step("rnd", ($urandom_range(0, 7) != 0), 0, $urandom_range(0, 15),
                     $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/morra_cinese_gen.md
Name: morra_cinese_gen

Overview:
- Parametrised next-generation Morra Cinese (rock-paper-scissors) match engine, replacing the fixed 4-bit-config, Mealy-output game FSMD.
- Adds a dedicated round-count config port, parametrised minimum rounds and win margin, and a VALID strobe so idle cycles do not consume rounds.
- Adds registered outputs with an explicit valid flag, and live score/round counters for the display/bench layer.

Parameters:
- CFG_W, 4, width of CFG. Max rounds = CFG + MIN_ROUNDS.
- MIN_ROUNDS, 4, rounds that must be counted before an early win can end the match.
- WIN_MARGIN, 2, score lead that ends the match early once MIN_ROUNDS are reached.
- CNT_W, derived, clog2(2**CFG_W - 1 + MIN_ROUNDS + 1). Width of score and round counters.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- VALID  in  1  sample INIZIA/PRIMO/SECONDO/CFG this cycle.
- INIZIA  in  1  1 = (re)start match and load CFG; 0 = play a round.
- CFG  in  CFG_W  round-count config, used only when INIZIA=1.
- PRIMO  in  2  P1 move: 00 none, 01 rock, 10 paper, 11 scissors.
- SECONDO  in  2  P2 move, same encoding.
- MANCHE_VALID  out  1  one-cycle pulse; MANCHE/PARTITA updated.
- MANCHE  out  2  00 invalid, 01 P1, 10 P2, 11 draw.
- PARTITA  out  2  00 not ended, 01 P1 winner, 10 P2 winner, 11 draw.
- SCORE1  out  CNT_W  P1 manches won.
- SCORE2  out  CNT_W  P2 manches won.
- ROUNDS  out  CNT_W  counted manches.

Behaviour:
- Reset values: async, rst_n=0 forces all outputs to 0, state to IDLE, and the move restriction to cleared. Reset mid-match abandons the match with no pulse.
- Timing: inputs are sampled at a posedge with VALID=1. Outputs are registered and appear after that same edge (latency 1). MANCHE_VALID=1 for exactly one cycle per sampled VALID.
- VALID=0: no state change; MANCHE_VALID=0; other outputs hold.
- States: IDLE, PLAY, DONE.
- INIZIA=1 (any state):
  - max_r <= CFG + MIN_ROUNDS, computed at CNT_W width with no overflow.
  - Scores and ROUNDS cleared; restriction cleared.
  - Go to PLAY; MANCHE=00, PARTITA=00.
- IDLE with INIZIA=0: MANCHE=00, PARTITA=00, stay in IDLE.
- PLAY with INIZIA=0: a move pair is invalid if either move is 00, or if it violates the restriction (see Optional Feature).
  - Invalid: MANCHE=00, nothing counted.
  - Valid: MANCHE = winner (rock>scissors, scissors>paper, paper>rock; equal moves = 11). ROUNDS+1; winner score +1.
- End check (same cycle, uses the post-update values):
  - if ROUNDS>=MIN_ROUNDS and |SCORE1-SCORE2|>=WIN_MARGIN: PARTITA = leader, go to DONE;
  - else if ROUNDS==max_r: PARTITA = 01/10/11 by score comparison, go to DONE;
  - else PARTITA=00.
- Simultaneous early and max end conditions: the early-win result applies (same value anyway).
- DONE with INIZIA=0: MANCHE=00, PARTITA holds the final result, counters hold.
- Score difference is computed at CNT_W+1 signed width.

Optional Feature:
- Macro MORRA_NO_REPEAT_EN.
- Defined: the winner of the last counted manche may not replay the move they won with. That player's move equal to the stored move makes the round invalid. The restriction is replaced on each decisive manche, cleared on a draw manche, and cleared on start.
- Undefined: no restriction register; only a 00 move makes a round invalid.

Decomposition:
- Package morra_pkg: move_t, manche_t, partita_t enums with the encodings above; state_t enum; function beats(a,b).
- One sub-module, morra_judge: combinational. Takes the two moves and the restriction info; returns validity and manche_t.
- morra_cinese_gen holds the FSM, counters and output registers.

Test Plan:
- Start with CFG=1 (5 rounds), then rock/paper, scissors/rock, paper/scissors, scissors/paper -> MANCHE 10,10,10,01. PARTITA 00,00,00,10 on round 4; ROUNDS=4, SCORE2=3.
- Start CFG=1; draws on scissors/scissors x3, then scissors/rock, then rock/scissors -> round 5 MANCHE=01, PARTITA=11, ROUNDS=5.
- With MORRA_NO_REPEAT_EN: after P2 wins with rock, rock/rock and paper/rock -> MANCHE=00 each, ROUNDS unchanged. Without the macro, rock/rock -> MANCHE=11.
- Moves 00/10 and VALID=0 cycles -> 00 invalid with no count; no MANCHE_VALID pulse while VALID=0.
- In DONE, play paper/rock -> MANCHE=00, PARTITA holds. INIZIA=1 with CFG=9 -> all counters 0, PARTITA=00; match then lasts at most 13 rounds.
- Assert rst_n low mid-match (ROUNDS=2) -> all outputs 0 immediately. Play without INIZIA -> MANCHE=00 (IDLE).
